// File: rtl/o_accum_norm_pkg.sv
// o_accum_norm shared types: Q9.17 star vectors,
// saturation limits and the accumulate/normalise FSM states.
package o_accum_norm_pkg;

    localparam int MAX_EMBEDDING_DIM = 4;
    localparam int DIM       = MAX_EMBEDDING_DIM + 1;
    localparam int DATA_W    = 27;
    localparam int FRAC      = 17;
    localparam int DVD_W     = DATA_W + FRAC;
    localparam int DIV_ITERS = DVD_W;
    localparam int LANE_W    = $clog2(DIM);

    typedef logic signed [DATA_W-1:0] star_t;
    typedef star_t [DIM-1:0] star_vector_t;

    localparam star_t STAR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam star_t STAR_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam star_t STAR_ONE = star_t'(1 << FRAC);

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        OUT
    } state_t;

    // 28-bit sum clamped back into the 27-bit signed range
    function automatic star_t sat_add(star_t a, star_t b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? STAR_MIN : STAR_MAX;
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/o_accum_norm_if.sv
// Upstream (expmul) and downstream handshake bundle
// for the O* accumulate/normalise stage.
interface o_accum_norm_if;
    import o_accum_norm_pkg::*;

    logic         vld_in;
    logic         rdy_out;
    logic         last_in;
    star_vector_t exp_o_in;
    star_vector_t exp_v_in;
    star_vector_t o_star_prev_out;
    logic         vld_out;
    logic         rdy_in;
    star_vector_t o_out;
    logic         div_err;

    modport master (
        output vld_in, last_in, exp_o_in, exp_v_in, rdy_in,
        input  rdy_out, o_star_prev_out, vld_out, o_out, div_err
    );

    modport slave (
        input  vld_in, last_in, exp_o_in, exp_v_in, rdy_in,
        output rdy_out, o_star_prev_out, vld_out, o_out, div_err
    );

endinterface

// File: rtl/o_accum_norm_seq_divider.sv
// Unsigned restoring divider, 44-bit dividend / 27-bit divisor,
// one load cycle then one quotient bit per cycle, saturating result.
module o_accum_norm_seq_divider
    import o_accum_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DVD_W-1:0]  dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    logic [DVD_W-1:0]  q_q;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] d_q;
    logic [5:0]        cnt_q;
    logic [DATA_W:0]   r_sh;
    logic [DATA_W:0]   r_sub;

    assign r_sh  = {r_q, q_q[DVD_W-1]};
    assign r_sub = r_sh - {1'b0, d_q};
    assign done  = busy && (cnt_q == '0);

    // anything above 26 magnitude bits clamps to STAR_MAX
    assign quotient = (|q_q[DVD_W-1:DATA_W-1])
                    ? STAR_MAX
                    : {1'b0, q_q[DATA_W-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt_q <= 6'(DIV_ITERS);
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
        end else if (busy && cnt_q != '0) begin
            cnt_q <= cnt_q - 6'd1;
            if (r_sh >= {1'b0, d_q}) begin
                r_q <= r_sub[DATA_W-1:0];
                q_q <= {q_q[DVD_W-2:0], 1'b1};
            end else begin
                r_q <= r_sh[DATA_W-1:0];
                q_q <= {q_q[DVD_W-2:0], 1'b0};
            end
        end else if (done) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/o_accum_norm.sv
// Accumulates exp_o+exp_v into O*, then on the row's last key
// divides lanes 1..DIM-1 by lane 0 with one shared serial divider.
module o_accum_norm
    import o_accum_norm_pkg::*;
(
    input logic           clk,
    input logic           rst,
    o_accum_norm_if.slave bus
);

    state_t            state_q, state_d;
    star_vector_t      o_star_q;
    star_vector_t      o_out_q;
    logic              div_err_q;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] div_lane;
    logic              start, busy, done;
    logic              last_lane, den_bad, acc_fire;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] num_mag;
    logic [DVD_W-1:0]  dividend;
    star_t             num, quot_s, res;

    assign acc_fire  = (state_q == ACCUM) && bus.vld_in;
    assign last_lane = lane_q == LANE_W'(DIM - 1);
    assign den_bad   = o_star_q[0][DATA_W-1] || (o_star_q[0] == '0);

    // a finishing lane hands the divider straight to the next lane
    assign div_lane = (done && !last_lane) ? lane_q + LANE_W'(1) : lane_q;
    assign num      = o_star_q[div_lane];
    assign num_mag  = num[DATA_W-1] ? DATA_W'(-num) : num;
    assign dividend = {num_mag, {FRAC{1'b0}}};

    assign quot_s = quot;
    assign res    = o_star_q[lane_q][DATA_W-1] ? -quot_s : quot_s;

    o_accum_norm_seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (o_star_q[0]),
        .busy     (busy),
        .done     (done),
        .quotient (quot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ACCUM;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (acc_fire && bus.last_in) state_d = DIV;
            end
            DIV: begin
                if (!busy) begin
                    if (den_bad) state_d = OUT;
                    else         start   = 1'b1;
                end else if (done) begin
                    if (last_lane) state_d = OUT;
                    else           start   = 1'b1;
                end
            end
            OUT: begin
                if (bus.rdy_in) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_star_q  <= '0;
            o_out_q   <= '0;
            div_err_q <= 1'b0;
            lane_q    <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (acc_fire) begin
                        for (int i = 0; i < DIM; i++)
                            o_star_q[i] <= sat_add(bus.exp_o_in[i],
                                                   bus.exp_v_in[i]);
                        if (bus.last_in) begin
                            lane_q     <= LANE_W'(1);
                            o_out_q[0] <= STAR_ONE;
                        end
                    end
                end
                DIV: begin
                    if (!busy && den_bad) begin
                        o_out_q   <= '0;
                        div_err_q <= 1'b1;
                    end else if (done) begin
                        o_out_q[lane_q] <= res;
                        if (!last_lane) lane_q <= lane_q + LANE_W'(1);
                    end
                end
                OUT: begin
                    if (bus.rdy_in) begin
                        o_star_q  <= '0;
                        div_err_q <= 1'b0;
                        lane_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy_out         = state_q == ACCUM;
    assign bus.vld_out         = state_q == OUT;
    assign bus.o_star_prev_out = o_star_q;
    assign bus.o_out           = o_out_q;
    assign bus.div_err         = div_err_q;

endmodule

// File: doc/o_accum_norm.md
Name: o_accum_norm

Overview:
- Stage directly downstream of expmul in the per-query FlashAttention datapath.
- Accumulates each key's rescaled contributions (exp_o + exp_v) into the running O* vector, and feeds O* back to expmul as o_star_prev.
- On the last key of a row, normalises O* by its element 0 (the running softmax denominator, carried as the "1.0" lane) using a serial divider, then emits the final output vector.

Parameters:
- DIM, `MAX_EMBEDDING_DIM+1: vector lanes; lane 0 is the denominator.
- DATA_W, 27: signed Q9.17 element width.
- FRAC, 17: fractional bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- vld_in  in  1  upstream (expmul) valid
- rdy_out  out  1  this block ready to accept
- exp_o_in  in  DIM x DATA_W  rescaled previous O* from expmul (STAR_VECTOR_T)
- exp_v_in  in  DIM x DATA_W  rescaled V* from expmul (STAR_VECTOR_T)
- last_in  in  1  this transfer is the row's last key
- o_star_prev_out  out  DIM x DATA_W  current O* register, fed back to expmul
- vld_out  out  1  normalised vector valid
- rdy_in  in  1  downstream ready
- o_out  out  DIM x DATA_W  normalised output, Q9.17
- div_err  out  1  denominator was <= 0 for this output; valid with vld_out

Behaviour:
- Reset (asynchronous, rst=0) values:
  - state=ACCUM, o_star=0, o_out=0.
  - vld_out=0, div_err=0, rdy_out=1, lane index=0.
- ACCUM state:
  - rdy_out=1.
  - On vld_in&&rdy_out: o_star[i] <= sat(exp_o_in[i] + exp_v_in[i]) for all lanes.
  - sat clamps the 28-bit sum to [-2^26, 2^26-1].
  - If last_in is also set: go to DIV with lane index=1; o_out[0] is set to 131072 (1.0).
- DIV state:
  - rdy_out=0; vld_in is ignored and never back-pressures into a lost transfer.
  - Lanes 1..DIM-1 are processed sequentially.
  - Per lane, the dividend is |o_star[i]|<<FRAC (44 bits) and the divisor is o_star[0].
  - Restoring division: 1 load cycle + 44 iteration cycles = 45 cycles per lane.
  - Quotient magnitude > 2^26-1 saturates to 2^26-1; the sign of o_star[i] is then reapplied. Rounding is toward zero.
  - Result is written to o_out[i]; after lane DIM-1, go to OUT.
  - If o_star[0] <= 0 on DIV entry: skip division, o_out=0 on all lanes, div_err=1, go to OUT next cycle.
- OUT state:
  - vld_out=1; o_out and div_err are held stable while rdy_in=0.
  - On vld_out&&rdy_in: vld_out <= 0, div_err <= 0, o_star <= 0, go to ACCUM. The next row starts from o_star_prev_out=0.
- Latency:
  - vld_out rises exactly 1+45*(DIM-1) cycles after the last-key handshake edge.
  - In the div_err case it rises 1 cycle after.
- Throughput: one accumulate per cycle in ACCUM.
- Reset mid-DIV/OUT: the operation is aborted; all state returns to reset values.

Decomposition:
- Shared package (sys_defs.svh):
  - STAR_VECTOR_T, Q9.17 width/frac constants, STAR_MAX/STAR_MIN saturation constants.
  - o_accum_norm state enum.
- Sub-module: seq_divider.
  - Unsigned restoring divider, 44-bit dividend, 27-bit divisor.
  - start/done handshake, saturating 27-bit quotient.
  - Instantiated once and reused across lanes.

Test Plan:
- Single-key row: exp_o=0, exp_v={131072, 262144, -131072, 0...}, last=1 -> o_out={131072, 262144, -131072, 0...}, div_err=0, vld_out exactly 1+45*(DIM-1) cycles after handshake.
- Two-key row: key0 exp_v={131072, 65536}, last=0 -> o_star_prev_out={131072, 65536}; key1 exp_o={131072, 65536}, exp_v={131072, 196608}, last=1 -> o_out[1]=131072.
- Saturation: exp_o[1]=2^26-1, exp_v[1]=100 -> o_star_prev_out[1]=2^26-1; with o_star[0]=1 and last=1 -> o_out[1]=2^26-1.
- Zero denominator: final o_star[0]=0 -> vld_out 1 cycle later, o_out all 0, div_err=1.
- Backpressure: rdy_in=0 for 10 cycles in OUT, vld_in pulsed -> o_out/vld_out stable, rdy_out=0, no accumulate; after rdy_in=1, o_star_prev_out=0 and rdy_out=1 next cycle.
- Reset mid-DIV: rst=0 at lane 3 -> vld_out=0, o_star=0, state ACCUM immediately; next row computes correctly.
